// File: rtl/dcache_pkg.sv
// Shared types and helpers for the write-back data cache.
package dcache_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WB_RD,
        WB_SEND,
        FILL_ADDR,
        FILL_DATA,
        FLUSH
    } state_t;

    localparam int unsigned PACK_W = 64;

    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned index_w,
                                              input int unsigned offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic int unsigned line_width(input int unsigned data_w,
                                               input int unsigned offset_w);
        return data_w << offset_w;
    endfunction

    // Line number {tag,idx} to a byte address with the in-line offset bits zeroed.
    function automatic logic [PACK_W-1:0] line_byte_addr(input logic [PACK_W-1:0] line_num,
                                                         input int unsigned low_bits);
        return line_num << low_bits;
    endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// Line data store: one sync-read bank per word, byte writes for stores, whole-line writes for fills.
module dcache_line_ram
    import dcache_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned INDEX_W  = 10,
    parameter int unsigned OFFSET_W = 2
) (
    input  logic                           clk,
    input  logic [INDEX_W-1:0]             raddr,
    output logic [(DATA_W<<OFFSET_W)-1:0]  rline,
    input  logic [INDEX_W-1:0]             waddr,
    input  logic                           word_we,
    input  logic [OFFSET_W-1:0]            word_off,
    input  logic [DATA_W/8-1:0]            wstrb,
    input  logic [DATA_W-1:0]              wdata,
    input  logic                           fill_we,
    input  logic [(DATA_W<<OFFSET_W)-1:0]  fill_line
);

    localparam int unsigned WORDS  = 1 << OFFSET_W;
    localparam int unsigned DEPTH  = 1 << INDEX_W;
    localparam int unsigned STRB_W = DATA_W / 8;

    for (genvar b = 0; b < WORDS; b++) begin : g_bank
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] rd_q;
        logic [STRB_W-1:0] be;
        logic [DATA_W-1:0] wd;

        // Byte enables and data for this bank: fills write every byte, stores only the addressed word.
        always_comb begin
            be = '0;
            wd = wdata;
            if (fill_we) begin
                be = '1;
                wd = fill_line[b*DATA_W +: DATA_W];
            end else if (word_we && (word_off == OFFSET_W'(b))) begin
                be = wstrb;
            end
        end

        // Byte-granular write and registered read.
        always_ff @(posedge clk) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (be[k]) mem[waddr][k*8 +: 8] <= wd[k*8 +: 8];
            end
            rd_q <= mem[raddr];
        end

        assign rline[b*DATA_W +: DATA_W] = rd_q;
    end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back data cache with dirty tracking, reset sweep and flush sweep.
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned INDEX_W    = 10,
    parameter int unsigned OFFSET_W   = 2,
    parameter int unsigned MEM_ADDR_W = 27
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    input  logic                           req_we,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [DATA_W-1:0]              req_wdata,
    input  logic [DATA_W/8-1:0]            req_wstrb,
    output logic                           req_ready,
    output logic [DATA_W-1:0]              rdata,
    output logic                           rdata_valid,
    input  logic                           flush_req,
    output logic                           flush_busy,
    output logic [MEM_ADDR_W-1:0]          wr_addr,
    output logic [(DATA_W<<OFFSET_W)-1:0]  wr_data,
    output logic                           wr_valid,
    input  logic                           wr_ready,
    output logic [MEM_ADDR_W-1:0]          rd_addr,
    output logic                           rd_avalid,
    input  logic                           rd_aready,
    input  logic [(DATA_W<<OFFSET_W)-1:0]  rd_data,
    input  logic                           rd_valid,
    output logic                           rd_dready
);

    localparam int unsigned TAG_W   = tag_width(ADDR_W, INDEX_W, OFFSET_W);
    localparam int unsigned LINE_W  = line_width(DATA_W, OFFSET_W);
    localparam int unsigned WORDS   = 1 << OFFSET_W;
    localparam int unsigned LINES   = 1 << INDEX_W;
    localparam int unsigned BYTE_SH = OFFSET_W + $clog2(DATA_W / 8);

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [OFFSET_W-1:0] req_off;

    logic [TAG_W-1:0]    tag_arr [LINES];
    logic [LINES-1:0]    valid_arr;
    logic [LINES-1:0]    dirty_arr;

    state_t              state, state_d;
    logic [INDEX_W-1:0]  sweep, sweep_d;
    logic                in_flush, in_flush_d;
    logic                pend, pend_d;
    logic                clr_vd, clr_dirty, word_we, fill_we, wr_load, rd_load, load_acc;
    logic                hit, last_idx;
    logic [INDEX_W-1:0]  raddr;
    logic [LINE_W-1:0]   line_q;
    logic [DATA_W-1:0]   line_words [WORDS];
    logic [OFFSET_W-1:0] off_q;

    function automatic logic [MEM_ADDR_W-1:0] mem_addr(input logic [TAG_W-1:0] t,
                                                       input logic [INDEX_W-1:0] i);
        return MEM_ADDR_W'(line_byte_addr(PACK_W'({t, i}), BYTE_SH));
    endfunction

    assign {req_tag, req_idx, req_off} = req_addr;
    assign hit       = valid_arr[req_idx] && (tag_arr[req_idx] == req_tag);
    assign last_idx  = &sweep;
    assign raddr     = in_flush ? sweep : req_idx;
    assign req_ready = (state == IDLE) && (!req_valid || hit) && !flush_req && !pend;

    // Split the read line into words for the load mux.
    always_comb begin
        for (int w = 0; w < WORDS; w++) line_words[w] = line_q[w*DATA_W +: DATA_W];
    end

    assign rdata = rdata_valid ? line_words[off_q] : '0;

    dcache_line_ram #(
        .DATA_W   (DATA_W),
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W)
    ) u_line_ram (
        .clk       (clk),
        .raddr     (raddr),
        .rline     (line_q),
        .waddr     (req_idx),
        .word_we   (word_we),
        .word_off  (req_off),
        .wstrb     (req_wstrb),
        .wdata     (req_wdata),
        .fill_we   (fill_we),
        .fill_line (rd_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_d;
    end

    // Next state, sweep control and array/RAM write strobes.
    always_comb begin
        state_d    = state;
        sweep_d    = sweep;
        in_flush_d = in_flush;
        pend_d     = pend | flush_req;
        clr_vd     = 1'b0;
        clr_dirty  = 1'b0;
        word_we    = 1'b0;
        fill_we    = 1'b0;
        wr_load    = 1'b0;
        rd_load    = 1'b0;
        load_acc   = 1'b0;
        case (state)
            INIT: begin
                clr_vd  = 1'b1;
                sweep_d = sweep + INDEX_W'(1);
                if (last_idx) state_d = IDLE;
            end
            IDLE: begin
                if (flush_req || pend) begin
                    state_d    = FLUSH;
                    sweep_d    = '0;
                    in_flush_d = 1'b1;
                    pend_d     = 1'b0;
                end else if (req_valid) begin
                    if (hit) begin
                        word_we  = req_we && (|req_wstrb);
                        load_acc = !req_we;
                    end else if (dirty_arr[req_idx]) begin
                        state_d = WB_RD;
                    end else begin
                        state_d = FILL_ADDR;
                        rd_load = 1'b1;
                    end
                end
            end
            WB_RD: begin
                wr_load = 1'b1;
                state_d = WB_SEND;
            end
            WB_SEND: begin
                if (wr_ready) begin
                    if (in_flush) begin
                        clr_dirty  = 1'b1;
                        sweep_d    = sweep + INDEX_W'(1);
                        state_d    = last_idx ? IDLE : FLUSH;
                        in_flush_d = !last_idx;
                    end else begin
                        state_d = FILL_ADDR;
                        rd_load = 1'b1;
                    end
                end
            end
            FILL_ADDR: begin
                if (rd_aready) state_d = FILL_DATA;
            end
            FILL_DATA: begin
                if (rd_valid) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (dirty_arr[sweep]) begin
                    state_d = WB_RD;
                end else begin
                    sweep_d = sweep + INDEX_W'(1);
                    if (last_idx) begin
                        state_d    = IDLE;
                        in_flush_d = 1'b0;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Sweep/flush bookkeeping and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep       <= '0;
            in_flush    <= 1'b0;
            pend        <= 1'b0;
            rdata_valid <= 1'b0;
            off_q       <= '0;
            wr_valid    <= 1'b0;
            rd_avalid   <= 1'b0;
            rd_dready   <= 1'b0;
            flush_busy  <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_addr     <= '0;
        end else begin
            sweep       <= sweep_d;
            in_flush    <= in_flush_d;
            pend        <= pend_d;
            rdata_valid <= load_acc;
            wr_valid    <= (state_d == WB_SEND);
            rd_avalid   <= (state_d == FILL_ADDR);
            rd_dready   <= (state_d == FILL_DATA);
            flush_busy  <= in_flush_d || pend_d;
            if (load_acc) off_q <= req_off;
            if (wr_load) begin
                wr_data <= line_q;
                wr_addr <= mem_addr(tag_arr[raddr], raddr);
            end
            if (rd_load) rd_addr <= mem_addr(req_tag, req_idx);
        end
    end

    // Tag, valid and dirty arrays.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_vd) begin
                valid_arr[sweep] <= 1'b0;
                dirty_arr[sweep] <= 1'b0;
            end
            if (clr_dirty) dirty_arr[sweep] <= 1'b0;
            if (word_we)   dirty_arr[req_idx] <= 1'b1;
            if (fill_we) begin
                tag_arr[req_idx]   <= req_tag;
                valid_arr[req_idx] <= 1'b1;
                dirty_arr[req_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Scoreboard bench for dcache_wb: golden word memory, backing line memory, stallable memory responder.
module tb_dcache_wb;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 25;
    localparam int unsigned MW = 27;
    localparam int unsigned LW = 128;

    typedef struct packed {
        logic          is_wr;
        logic [MW-1:0] a;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_we, req_ready, rdata_valid;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata, rdata;
    logic [3:0]    req_wstrb;
    logic          flush_req, flush_busy;
    logic [MW-1:0] wr_addr, rd_addr;
    logic [LW-1:0] wr_data, rd_data;
    logic          wr_valid, wr_ready, rd_avalid, rd_aready, rd_valid, rd_dready;

    always #5 clk = ~clk;

    dcache_wb #(
        .DATA_W(32), .ADDR_W(25), .INDEX_W(10), .OFFSET_W(2), .MEM_ADDR_W(27)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .rdata(rdata), .rdata_valid(rdata_valid),
        .flush_req(flush_req), .flush_busy(flush_busy),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_addr(rd_addr), .rd_avalid(rd_avalid), .rd_aready(rd_aready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_dready(rd_dready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Golden CPU-visible memory and backing memory.
    logic [31:0]   gold [int];
    logic [LW-1:0] bmem [int];
    logic [DW-1:0] exp_q [$];
    ev_t           ev_q  [$];

    function automatic logic [31:0] init_word(input logic [AW-1:0] wa);
        logic [15:0] lo;
        lo = wa[15:0];
        return {~lo, lo} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] gold_rd(input logic [AW-1:0] wa);
        if (gold.exists(int'(wa))) return gold[int'(wa)];
        return init_word(wa);
    endfunction

    function automatic logic [MW-1:0] line_addr(input logic [AW-1:0] wa);
        return {wa[AW-1:2], 4'b0000};
    endfunction

    function automatic logic [LW-1:0] golden_line(input logic [MW-1:0] la);
        logic [LW-1:0] l;
        logic [AW-1:0] base;
        base = AW'(la >> 2);
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = gold_rd(base + AW'(w));
        return l;
    endfunction

    function automatic logic [LW-1:0] bmem_line(input logic [MW-1:0] la);
        logic [LW-1:0] l;
        logic [AW-1:0] base;
        if (bmem.exists(int'(la))) return bmem[int'(la)];
        base = AW'(la >> 2);
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = init_word(base + AW'(w));
        return l;
    endfunction

    function automatic ev_t ev_at(input int i);
        if (i < ev_q.size()) return ev_q[i];
        return '1;
    endfunction

    // Memory responder: each channel waits mem_delay cycles before its handshake.
    int            mem_delay = 0;
    int            wr_wait = 0, ra_wait = 0, rd_wait = 0;
    int            wb_count = 0;
    bit            rdy_bad = 1'b0;
    logic [MW-1:0] wr_a0, ra_a0, fill_a;
    logic [LW-1:0] wr_d0;

    initial begin
        wr_ready  = 1'b0;
        rd_aready = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        forever begin
            @(negedge clk);
            if (wr_valid) begin
                if (wr_wait == 0) begin
                    wr_a0 = wr_addr;
                    wr_d0 = wr_data;
                end
                if (wr_wait >= mem_delay) begin
                    wr_ready = 1'b1;
                    if (mem_delay > 0) check("wb_stable", {wr_addr, wr_data}, {wr_a0, wr_d0});
                    check("wb_data", wr_data, golden_line(wr_addr));
                    bmem[int'(wr_addr)] = wr_data;
                    wb_count++;
                    ev_q.push_back({1'b1, wr_addr});
                end else begin
                    wr_ready = 1'b0;
                    if (req_ready) rdy_bad = 1'b1;
                end
                wr_wait++;
            end else begin
                wr_ready = 1'b0;
                wr_wait  = 0;
            end
            if (rd_avalid) begin
                if (ra_wait == 0) ra_a0 = rd_addr;
                if (ra_wait >= mem_delay) begin
                    rd_aready = 1'b1;
                    if (mem_delay > 0) check("fill_addr_stable", rd_addr, ra_a0);
                    fill_a = rd_addr;
                    ev_q.push_back({1'b0, rd_addr});
                end else begin
                    rd_aready = 1'b0;
                    if (req_ready) rdy_bad = 1'b1;
                end
                ra_wait++;
            end else begin
                rd_aready = 1'b0;
                ra_wait   = 0;
            end
            if (rd_dready) begin
                if (rd_wait >= mem_delay) begin
                    rd_valid = 1'b1;
                    rd_data  = bmem_line(fill_a);
                end else begin
                    rd_valid = 1'b0;
                    if (req_ready) rdy_bad = 1'b1;
                end
                rd_wait++;
            end else begin
                rd_valid = 1'b0;
                rd_wait  = 0;
            end
        end
    end

    // Load-data scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rdata_valid) begin
                if (exp_q.size() == 0) check("rdata_unexpected", exp_q.size(), 1);
                else                   check("rdata", rdata, exp_q.pop_front());
            end
        end
    end

    // One CPU access held until accepted; returns the number of stalled cycles.
    task automatic cpu(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] s, output int waited);
        logic [31:0] old;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        #1;
        waited = 0;
        while (!req_ready && waited < 2000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!req_ready) begin
            check("cpu_accept", req_ready, 1);
        end else if (we) begin
            old = gold_rd(a);
            for (int k = 0; k < 4; k++) if (s[k]) old[k*8 +: 8] = d[k*8 +: 8];
            gold[int'(a)] = old;
        end else begin
            exp_q.push_back(gold_rd(a));
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int w, cnt, wb0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        flush_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_flush_busy", flush_busy, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_rd_avalid", rd_avalid, 0);

        // Reset sweep length.
        rst = 1'b0;
        #1;
        cnt = 0;
        while (!req_ready && cnt < 2000) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        check("init_len", cnt, 1024);

        // Cold load: fill then hit on retry.
        ev_q.delete();
        cpu(1'b0, 25'h000010, '0, '0, w);
        check("cold_events", ev_q.size(), 1);
        check("cold_rd_addr", ev_at(0), {1'b0, line_addr(25'h000010)});

        // Partial store on a hit, then read-back.
        cpu(1'b1, 25'h000010, 32'hDEADBEEF, 4'b0011, w);
        check("store_hit_nostall", w, 0);
        cpu(1'b0, 25'h000010, '0, '0, w);
        cpu(1'b0, 25'h000011, '0, '0, w);
        check("no_wb_after_store", wb_count, 0);

        // Zero-strobe store must not dirty the line.
        cpu(1'b0, 25'h000050, '0, '0, w);
        cpu(1'b1, 25'h000050, 32'h12345678, 4'b0000, w);
        ev_q.delete();
        cpu(1'b0, 25'h001050, '0, '0, w);
        check("wstrb0_events", ev_q.size(), 1);
        check("wstrb0_fill", ev_at(0), {1'b0, line_addr(25'h001050)});

        // Conflict miss on the dirty line: write-back precedes fill.
        ev_q.delete();
        wb0 = wb_count;
        cpu(1'b0, 25'h001010, '0, '0, w);
        check("conflict_wb_count", wb_count - wb0, 1);
        check("conflict_ev0", ev_at(0), {1'b1, line_addr(25'h000010)});
        check("conflict_ev1", ev_at(1), {1'b0, line_addr(25'h001010)});

        // Slow memory on a dirty miss.
        cpu(1'b1, 25'h001011, 32'hCAFEF00D, 4'hF, w);
        mem_delay = 20;
        rdy_bad   = 1'b0;
        ev_q.delete();
        cpu(1'b0, 25'h000012, '0, '0, w);
        check("stall_ready_low", rdy_bad, 0);
        check("stall_wait_ge60", w >= 60, 1);
        check("stall_ev0", ev_at(0), {1'b1, line_addr(25'h001010)});
        check("stall_ev1", ev_at(1), {1'b0, line_addr(25'h000012)});
        mem_delay = 0;
        cpu(1'b0, 25'h000010, '0, '0, w);

        // Three dirty lines, then flush.
        cpu(1'b1, 25'h000013, 32'h0BADF00D, 4'b1100, w);
        cpu(1'b1, 25'h000020, 32'h11112222, 4'hF, w);
        cpu(1'b1, 25'h000030, 32'h33334444, 4'b0101, w);
        ev_q.delete();
        wb0 = wb_count;
        pulse_flush();
        check("flush_busy_rise", flush_busy, 1);
        cnt = 0;
        while (flush_busy && cnt < 5000) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        check("flush_busy_fall", flush_busy, 0);
        check("flush_wb_count", wb_count - wb0, 3);
        check("flush_ev0", ev_at(0), {1'b1, line_addr(25'h000010)});
        check("flush_ev1", ev_at(1), {1'b1, line_addr(25'h000020)});
        check("flush_ev2", ev_at(2), {1'b1, line_addr(25'h000030)});
        check("flush_ready", req_ready, 1);

        // Lines stay valid after flush.
        ev_q.delete();
        cpu(1'b0, 25'h000020, '0, '0, w);
        check("post_flush_hit", w, 0);
        check("post_flush_no_mem", ev_q.size(), 0);

        // Re-flush of a clean cache: no write-backs, one cycle per line.
        wb0 = wb_count;
        pulse_flush();
        cnt = 0;
        while (flush_busy && cnt < 5000) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        check("reflush_len", cnt, 1024);
        check("reflush_wb_count", wb_count - wb0, 0);

        // Reset in the middle of a fill.
        mem_delay = 20;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 25'h003000;
        req_wstrb = '0;
        cnt = 0;
        #1;
        while (!rd_avalid && cnt < 50) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        check("midrst_rd_avalid_seen", rd_avalid, 1);
        rst       = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_rd_avalid", rd_avalid, 0);
        check("midrst_rd_dready", rd_dready, 0);
        check("midrst_req_ready", req_ready, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
